// File: rtl/exc_commit_arbiter_pkg.sv
// Shared definitions for the commit-stage exception arbiter: exception codes, vector bit
// indices, CP0 register numbers and the flush FSM state type.
package exc_commit_arbiter_pkg;

  localparam int unsigned NumExcBits = 9;

  localparam logic [4:0] ExcInt  = 5'h00;
  localparam logic [4:0] ExcAdel = 5'h04;
  localparam logic [4:0] ExcAdes = 5'h05;
  localparam logic [4:0] ExcSys  = 5'h08;
  localparam logic [4:0] ExcBp   = 5'h09;
  localparam logic [4:0] ExcRi   = 5'h0A;
  localparam logic [4:0] ExcOv   = 5'h0C;
  localparam logic [4:0] ExcTr   = 5'h0D;
  localparam logic [4:0] ExcEret = 5'h0E;

  localparam int unsigned ExcBitFetchAdel = 0;
  localparam int unsigned ExcBitRi        = 1;
  localparam int unsigned ExcBitOv        = 2;
  localparam int unsigned ExcBitTr        = 3;
  localparam int unsigned ExcBitSys       = 4;
  localparam int unsigned ExcBitBp        = 5;
  localparam int unsigned ExcBitLoadAdel  = 6;
  localparam int unsigned ExcBitAdes      = 7;
  localparam int unsigned ExcBitEret      = 8;

  localparam logic [4:0] Cp0RegStatus = 5'd12;
  localparam logic [4:0] Cp0RegCause  = 5'd13;
  localparam logic [4:0] Cp0RegEpc    = 5'd14;
  localparam logic [4:0] Cp0RegEbase  = 5'd15;
  localparam logic [2:0] Cp0SelEbase  = 3'd1;

  typedef enum logic [0:0] {StIdle, StFlush} arb_state_e;

  function automatic logic [4:0] exc_bit_code(input int idx);
    logic [4:0] code;
    case (idx)
      ExcBitFetchAdel: code = ExcAdel;
      ExcBitRi:        code = ExcRi;
      ExcBitOv:        code = ExcOv;
      ExcBitTr:        code = ExcTr;
      ExcBitSys:       code = ExcSys;
      ExcBitBp:        code = ExcBp;
      ExcBitLoadAdel:  code = ExcAdel;
      ExcBitAdes:      code = ExcAdes;
      ExcBitEret:      code = ExcEret;
      default:         code = ExcInt;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/exc_commit_arbiter_prio.sv
// Per-slot priority encoder: lowest set exception bit wins and is mapped to its cause code.
module exc_prio_enc
  import exc_commit_arbiter_pkg::*;
(
  input  logic [NumExcBits-1:0] exc_vec,
  output logic                  hit,
  output logic [4:0]            code
);

  always_comb begin
    hit  = |exc_vec;
    code = ExcInt;
    // Walk from lowest to highest priority so the highest-priority bit is written last.
    for (int i = NumExcBits - 1; i >= 0; i--) begin
      if (exc_vec[i]) code = exc_bit_code(i);
    end
  end

endmodule

// File: rtl/exc_commit_arbiter.sv
// Commit-stage exception arbiter: picks at most one exception per cycle, then issues a
// registered flush and redirect. Define EXC_INT_SYNC_EN to synchronize cause_i[15:10].
module exc_commit_arbiter
  import exc_commit_arbiter_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst1_valid_i,
  input  logic                  inst2_valid_i,
  input  logic [NumExcBits-1:0] inst1_exc_i,
  input  logic [NumExcBits-1:0] inst2_exc_i,
  input  logic [31:0]           status_i,
  input  logic [31:0]           cause_i,
  input  logic [31:0]           epc_i,
  input  logic [31:0]           ebase_i,
  input  logic                  cp0_we_i,
  input  logic [4:0]            cp0_waddr_i,
  input  logic [2:0]            cp0_wsel_i,
  input  logic [31:0]           cp0_wdata_i,
  output logic                  exception_flag_o,
  output logic [4:0]            exception_type_o,
  output logic                  exception_first_inst_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  redirect_o
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  logic [7:0] irq_bits;

`ifdef EXC_INT_SYNC_EN
  logic [5:0] irq_meta_q, irq_sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_meta_q <= '0;
      irq_sync_q <= '0;
    end else begin
      irq_meta_q <= cause_i[15:10];
      irq_sync_q <= irq_meta_q;
    end
  end

  assign irq_bits = {irq_sync_q, cause_i[9:8]};
`else
  assign irq_bits = cause_i[15:8];
`endif

  logic int_pend;
  assign int_pend = (|(irq_bits & status_i[15:8])) & status_i[0] & ~status_i[1];

  logic       hit1, hit2;
  logic [4:0] code1, code2;

  exc_prio_enc u_enc1 (
    .exc_vec (inst1_exc_i),
    .hit     (hit1),
    .code    (code1)
  );

  exc_prio_enc u_enc2 (
    .exc_vec (inst2_exc_i),
    .hit     (hit2),
    .code    (code2)
  );

  logic       sel_hit, sel_first;
  logic [4:0] sel_code;

  always_comb begin
    sel_hit   = 1'b0;
    sel_first = 1'b0;
    sel_code  = ExcInt;
    if (int_pend && (inst1_valid_i || inst2_valid_i)) begin
      sel_hit   = 1'b1;
      sel_first = inst1_valid_i;
    end else if (inst1_valid_i && hit1) begin
      sel_hit   = 1'b1;
      sel_first = 1'b1;
      sel_code  = code1;
    end else if (inst2_valid_i && hit2) begin
      sel_hit  = 1'b1;
      sel_code = code2;
    end
  end

  // A slot-1 MTC0 to EPC has not reached epc_i yet, so an ERET behind it takes the write data.
  logic        epc_fwd;
  logic [31:0] target;
  assign epc_fwd = cp0_we_i && (cp0_waddr_i == Cp0RegEpc) && (cp0_wsel_i == 3'd0) && !sel_first;
  assign target  = (sel_code == ExcEret) ? (epc_fwd ? cp0_wdata_i : epc_i) : ebase_i;

  arb_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        redirect_q, redirect_d;
  logic [31:0] new_pc_q, new_pc_d;
  logic        take;

  assign take = (state_q == StIdle) && sel_hit;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    new_pc_d   = new_pc_q;
    unique case (state_q)
      StIdle: begin
        if (take) begin
          state_d    = StFlush;
          cnt_d      = FlushLoad;
          redirect_d = 1'b1;
          new_pc_d   = target;
        end
      end
      StFlush: begin
        if (cnt_q == 3'd0) state_d = StIdle;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
      new_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
      new_pc_q   <= new_pc_d;
    end
  end

  assign exception_flag_o       = take;
  assign exception_type_o       = take ? sel_code : ExcInt;
  assign exception_first_inst_o = take & sel_first;
  assign flush_o                = (state_q == StFlush);
  assign redirect_o             = redirect_q;
  assign new_pc_o               = new_pc_q;

  logic unused_bits;
  assign unused_bits = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0]};

endmodule

// File: tb/tb_exc_commit_arbiter.sv
// Randomized bench for exc_commit_arbiter against a cycle-level reference model.
module tb_exc_commit_arbiter;

  localparam int unsigned F = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst1_valid_i, inst2_valid_i;
  logic [8:0]  inst1_exc_i, inst2_exc_i;
  logic [31:0] status_i, cause_i, epc_i, ebase_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic [2:0]  cp0_wsel_i;
  logic [31:0] cp0_wdata_i;
  logic        exception_flag_o, exception_first_inst_o, flush_o, redirect_o;
  logic [4:0]  exception_type_o;
  logic [31:0] new_pc_o;

  exc_commit_arbiter #(.FLUSH_CYCLES(F)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .inst1_valid_i          (inst1_valid_i),
    .inst2_valid_i          (inst2_valid_i),
    .inst1_exc_i            (inst1_exc_i),
    .inst2_exc_i            (inst2_exc_i),
    .status_i               (status_i),
    .cause_i                (cause_i),
    .epc_i                  (epc_i),
    .ebase_i                (ebase_i),
    .cp0_we_i               (cp0_we_i),
    .cp0_waddr_i            (cp0_waddr_i),
    .cp0_wsel_i             (cp0_wsel_i),
    .cp0_wdata_i            (cp0_wdata_i),
    .exception_flag_o       (exception_flag_o),
    .exception_type_o       (exception_type_o),
    .exception_first_inst_o (exception_first_inst_o),
    .flush_o                (flush_o),
    .new_pc_o               (new_pc_o),
    .redirect_o             (redirect_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: flush cycles still owed, pending redirect and its target.
  int          busy;
  logic        exp_redir;
  logic [31:0] exp_pc;
  logic        e_flag, e_first;
  logic [4:0]  e_type;
  logic [31:0] e_target;
  int          code_of [9] = '{4, 10, 12, 13, 8, 9, 4, 5, 14};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [8:0] v);
    for (int i = 0; i < 9; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic predict();
    bit intp;
    intp = ((cause_i[15:8] & status_i[15:8]) != 8'd0) && status_i[0] && !status_i[1];
    e_flag  = 1'b0;
    e_first = 1'b0;
    e_type  = 5'd0;
    if (busy == 0) begin
      if (intp && (inst1_valid_i || inst2_valid_i)) begin
        e_flag  = 1'b1;
        e_first = inst1_valid_i;
      end else if (inst1_valid_i && inst1_exc_i != 9'd0) begin
        e_flag  = 1'b1;
        e_first = 1'b1;
        e_type  = 5'(code_of[lowest(inst1_exc_i)]);
      end else if (inst2_valid_i && inst2_exc_i != 9'd0) begin
        e_flag  = 1'b1;
        e_type  = 5'(code_of[lowest(inst2_exc_i)]);
      end
    end
    if (e_type == 5'h0E)
      e_target = (!e_first && cp0_we_i && cp0_waddr_i == 5'd14 && cp0_wsel_i == 3'd0)
                 ? cp0_wdata_i : epc_i;
    else
      e_target = ebase_i;
  endtask

  // Inputs are already applied; checks land on the falling edge, model advances on the rise.
  task automatic step();
    predict();
    @(negedge clk);
    check("flag", 32'(exception_flag_o), 32'(e_flag));
    if (e_flag) begin
      check("type", 32'(exception_type_o), 32'(e_type));
      check("first", 32'(exception_first_inst_o), 32'(e_first));
    end
    check("flush", 32'(flush_o), 32'(busy > 0));
    check("redirect", 32'(redirect_o), 32'(exp_redir));
    if (exp_redir) check("new_pc", new_pc_o, exp_pc);
    @(posedge clk);
    if (e_flag) begin
      busy      = F;
      exp_redir = 1'b1;
      exp_pc    = e_target;
    end else begin
      if (busy > 0) busy--;
      exp_redir = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    inst1_valid_i = 1'b0; inst2_valid_i = 1'b0;
    inst1_exc_i   = '0;   inst2_exc_i   = '0;
    status_i      = '0;   cause_i       = '0;
    epc_i         = '0;   ebase_i       = 32'hBFC0_0380;
    cp0_we_i      = 1'b0; cp0_waddr_i   = '0;
    cp0_wsel_i    = '0;   cp0_wdata_i   = '0;
  endtask

  task automatic settle();
    clear_inputs();
    repeat (F + 1) step();
  endtask

  function automatic logic [8:0] rand_vec();
    case ($urandom_range(0, 3))
      0:       return 9'd0;
      1:       return 9'(1 << $urandom_range(0, 8));
      default: return 9'($urandom);
    endcase
  endfunction

  initial begin
    busy = 0; exp_redir = 1'b0; exp_pc = '0;
    clear_inputs();
    rst = 1'b0;
    #12;
    check("rst_flush", 32'(flush_o), 32'd0);
    check("rst_redirect", 32'(redirect_o), 32'd0);
    check("rst_new_pc", new_pc_o, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Slot-1 overflow to EBase
    inst1_valid_i = 1'b1; inst1_exc_i = 9'b0_0000_0100;
    step();
    inst1_exc_i = '0;
    step(); step();
    settle();

    // Clean slot 1, slot-2 syscall
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1; inst2_exc_i = 9'b0_0001_0000;
    step();
    settle();

    // Interrupt beats a slot-2 RI and attaches to slot 1
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1; inst2_exc_i = 9'b0_0000_0010;
    step();
    settle();

    // Interrupt waits for a valid instruction
    status_i = 32'h0000_0401; cause_i = 32'h0000_0400;
    repeat (3) step();
    inst2_valid_i = 1'b1;
    step();
    settle();

    // ERET forwarded from a slot-1 MTC0 EPC
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1; inst2_exc_i = 9'b1_0000_0000;
    cp0_we_i = 1'b1; cp0_waddr_i = 5'd14; cp0_wsel_i = 3'd0; cp0_wdata_i = 32'h8000_1234;
    step();
    clear_inputs();
    step();
    settle();

    // Slot-1 RI versus slot-2 Sys
    inst1_valid_i = 1'b1; inst2_valid_i = 1'b1;
    inst1_exc_i = 9'b0_0000_0010; inst2_exc_i = 9'b0_0001_0000;
    step();
    settle();

    // Exception, new vector during flush, then asynchronous reset mid-flush
    inst1_valid_i = 1'b1; inst1_exc_i = 9'b0_0010_0000;
    step();
    inst1_exc_i = 9'b0_0000_0010;
    #2;
    check("flag_in_flush", 32'(exception_flag_o), 32'd0);
    check("flush_on", 32'(flush_o), 32'd1);
    rst = 1'b0;
    #1;
    check("rst_mid_flush", 32'(flush_o), 32'd0);
    check("rst_mid_redirect", 32'(redirect_o), 32'd0);
    busy = 0; exp_redir = 1'b0; exp_pc = '0;
    clear_inputs();
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    repeat (3) step();

    for (int n = 0; n < 500; n++) begin
      inst1_valid_i = 1'($urandom);
      inst2_valid_i = 1'($urandom);
      inst1_exc_i   = rand_vec();
      inst2_exc_i   = rand_vec();
      status_i      = {16'h0, 8'($urandom), 6'h0, 2'($urandom)};
      cause_i       = ($urandom_range(0, 3) == 0) ? {16'h0, 8'($urandom), 8'h0} : 32'h0;
      epc_i         = $urandom;
      ebase_i       = $urandom;
      cp0_we_i      = 1'($urandom);
      cp0_waddr_i   = $urandom_range(0, 1) == 0 ? 5'd14 : 5'($urandom);
      cp0_wsel_i    = $urandom_range(0, 1) == 0 ? 3'd0 : 3'($urandom);
      cp0_wdata_i   = $urandom;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
